// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for both ends of the APB link to the UART register
// completer: FSM state encoding and default bus widths.
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 4;
  localparam int APB_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ---------------------------------------------------------------------------
// apb_timeout_ctr
// Counts PREADY-low ACCESS cycles for the APB requester and flags when the
// allowed wait budget has been used up.
//   clk      : clock (rising edge)
//   rst      : synchronous active-high reset
//   clear    : restart the count (asserted the cycle before ACCESS)
//   count_en : one more wait cycle observed
//   expired  : count has reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES));

  // Saturate at the limit; the requester leaves ACCESS on that edge anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (count_en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// APB requester for a single completer. Takes one read/write command at a
// time from a local controller, runs the SETUP/ACCESS phases, honours PREADY
// wait states and returns read data / error on a one-cycle response strobe.
//
// Ports
//   PCLK, PRESET            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (accepted only in IDLE)
//   cmd_write/addr/wdata    : command fields, sampled at acceptance only
//   rsp_valid/rdata/err     : one-cycle completion strobe with result
//   PADDR..PWDATA, PSELx,
//   PENABLE                 : APB requester outputs (all registered)
//   PREADY/PRDATA/PSLVERR   : APB completer inputs, sampled in ACCESS only
//
// Optional feature: define APB_TIMEOUT_EN to abort a transfer (rsp_err = 1)
// once TIMEOUT_CYCLES PREADY-low ACCESS cycles have elapsed and PREADY is
// still low. Without it the block waits for PREADY indefinitely.
// ---------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  apb_state_t state_q;
  logic       expired;

  // Gated by PRESET so nothing is accepted on the reset edge.
  assign cmd_ready = (state_q == IDLE) && !PRESET;

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (PCLK),
    .rst      (PRESET),
    .clear    (state_q == SETUP),
    .count_en ((state_q == ACCESS) && !PREADY),
    .expired  (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // PADDR/PWRITE/PWDATA are written only on acceptance, so they stay stable
  // through the whole transfer and until the next command.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            PWDATA  <= cmd_wdata;
            PSELx   <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            // Normal completion wins over a timeout on the same edge.
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            state_q   <= IDLE;
          end else if (expired) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Directed and randomized transfers against a transaction-level timeline
// model: for a command accepted at edge 0 with W wait states the bus must
// show SETUP in cycle 1, ACCESS in cycles 2..2+W, and the response in cycle
// 3+W. Bus fields must hold the last accepted command at all times.
// ---------------------------------------------------------------------------
module tb_apb_master;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSELx, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] PRDATA;

  apb_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // Model: the last accepted command, which the bus fields must reflect.
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_write;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_paddr"},  32'(PADDR),  32'(m_addr));
    chk({tag, "_pwdata"}, 32'(PWDATA), 32'(m_wdata));
    chk({tag, "_pwrite"}, 32'(PWRITE), 32'(m_write));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_psel"},    32'(PSELx),     0);
    chk({tag, "_penable"}, 32'(PENABLE),   0);
    chk({tag, "_ready"},   32'(cmd_ready), 1);
    chk_fields(tag);
  endtask

  // One idle cycle with junk on the ignored command fields.
  task automatic idle_cycle();
    @(negedge PCLK);
    chk("idle_rsp", 32'(rsp_valid), 0);
    chk_idle("idle");
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    PREADY    = 1'($urandom);
    PSLVERR   = 1'($urandom);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // response cycle (DUT idle again). With hold=1 cmd_valid stays high
  // through SETUP/ACCESS carrying junk that must be ignored.
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input logic [DW-1:0] rd, input bit err, input bit hold);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    chk("acc_ready", 32'(cmd_ready), 1);
    @(posedge PCLK);
    m_addr = a; m_wdata = wd; m_write = wr;
    @(negedge PCLK);
    chk("setup_psel",    32'(PSELx),     1);
    chk("setup_penable", 32'(PENABLE),   0);
    chk("setup_ready",   32'(cmd_ready), 0);
    chk("setup_rsp",     32'(rsp_valid), 0);
    chk_fields("setup");
    cmd_valid = hold;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    PREADY    = 1'($urandom);
    PSLVERR   = 1'($urandom);
    PRDATA    = DW'($urandom);
    for (int i = 0; i <= waits; i++) begin
      @(negedge PCLK);
      chk("acc_psel",    32'(PSELx),     1);
      chk("acc_penable", 32'(PENABLE),   1);
      chk("acc_ready",   32'(cmd_ready), 0);
      chk("acc_rsp",     32'(rsp_valid), 0);
      chk_fields("access");
      PREADY  = (i == waits);
      PRDATA  = (i == waits) ? rd  : DW'($urandom);
      PSLVERR = (i == waits) ? err : 1'($urandom);
    end
    @(negedge PCLK);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_err",   32'(rsp_err),   32'(err));
    chk("rsp_rdata", 32'(rsp_rdata), (!wr && !err) ? 32'(rd) : 0);
    chk_idle("rsp");
    cmd_valid = 1'b0;
    PREADY    = 1'($urandom);
    PSLVERR   = 1'($urandom);
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 4'hF; cmd_wdata = 16'hBEEF;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 16'h5A5A;
    m_addr = '0; m_wdata = '0; m_write = 1'b0;

    // Reset state (cmd_valid high must not be accepted)
    repeat (3) @(negedge PCLK);
    chk("rst_ready",   32'(cmd_ready), 0);
    chk("rst_psel",    32'(PSELx),     0);
    chk("rst_penable", 32'(PENABLE),   0);
    chk("rst_rsp",     32'(rsp_valid), 0);
    chk("rst_err",     32'(rsp_err),   0);
    chk("rst_rdata",   32'(rsp_rdata), 0);
    chk_fields("rst");
    PRESET = 1'b0; cmd_valid = 1'b0;
    idle_cycle();

    // Write with zero waits
    xfer(1'b1, 4'h2, 16'h00A5, 0, 16'h7777, 1'b0, 1'b0);
    idle_cycle();
    // Read with 3 wait states
    xfer(1'b0, 4'h4, 16'h0000, 3, 16'h1234, 1'b0, 1'b0);
    idle_cycle();
    // Error read
    xfer(1'b0, 4'h6, 16'h0000, 0, 16'hFFFF, 1'b1, 1'b0);
    idle_cycle();
    // Error write
    xfer(1'b1, 4'h9, 16'hC3C3, 1, 16'h4321, 1'b1, 1'b0);
    idle_cycle();

    // Back-to-back with cmd_valid held high: accepts 3 cycles apart, one
    // IDLE cycle (checked in the response cycle) between transfers.
    xfer(1'b1, 4'h1, 16'h1111, 0, 16'h0, 1'b0, 1'b1);
    xfer(1'b0, 4'h3, 16'h2222, 0, 16'hABCD, 1'b0, 1'b1);
    xfer(1'b1, 4'h5, 16'h3333, 0, 16'h0, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();

    // Reset mid-transfer during ACCESS with PREADY low
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hA; cmd_wdata = 16'h9999;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    chk("mid_penable", 32'(PENABLE), 1);
    PRESET = 1'b1;
    #1;
    chk("mid_ready_rst", 32'(cmd_ready), 0);
    @(negedge PCLK);
    m_addr = '0; m_wdata = '0; m_write = 1'b0;
    chk("mid_psel",    32'(PSELx),     0);
    chk("mid_penable0",32'(PENABLE),   0);
    chk("mid_rsp",     32'(rsp_valid), 0);
    chk("mid_err",     32'(rsp_err),   0);
    chk("mid_rdata",   32'(rsp_rdata), 0);
    chk_fields("mid");
    PRESET = 1'b0; PREADY = 1'b1;
    idle_cycle();
    idle_cycle();

`ifdef APB_TIMEOUT_EN
    // Timeout: TO counted wait cycles allowed; with PREADY still low when
    // the count reaches TO the transfer aborts with an error.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hC; cmd_wdata = 16'h0;
    @(posedge PCLK);
    m_addr = 4'hC; m_wdata = 16'h0; m_write = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0; PREADY = 1'b0; PRDATA = 16'hDEAD; PSLVERR = 1'b0;
    for (int i = 0; i <= TO; i++) begin
      @(negedge PCLK);
      chk("to_penable", 32'(PENABLE),   1);
      chk("to_rsp",     32'(rsp_valid), 0);
    end
    @(negedge PCLK);
    chk("to_valid", 32'(rsp_valid), 1);
    chk("to_err",   32'(rsp_err),   1);
    chk("to_rdata", 32'(rsp_rdata), 0);
    chk_idle("to");
    PREADY = 1'b1;
    idle_cycle();
`endif

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      automatic bit            wr   = 1'($urandom);
      automatic logic [AW-1:0] a    = AW'($urandom);
      automatic logic [DW-1:0] wd   = DW'($urandom);
      automatic logic [DW-1:0] rd   = DW'($urandom);
      automatic bit            err  = ($urandom_range(0, 3) == 0);
      automatic int            w    = $urandom_range(0, TO);
      automatic int            gaps = $urandom_range(0, 2);
      xfer(wr, a, wd, w, rd, err, 1'($urandom));
      for (int g = 0; g < gaps; g++) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
